// File: rtl/estimador_func_mvmult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : estimador_func_mvmult_pkg
// Brief    : Shared types and helpers for the estimator matrix-vector multiplier
// Revision : 1.0
// ============================================================================
package estimador_func_mvmult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(n)) r = r + 1;
      end
      return r;
   endfunction

   function automatic int clog2_min1(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   // Saturation limits of a W-bit two's complement word (W <= 63)
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/estimador_func_mvmult_sat_round.sv
`default_nettype none
// ============================================================================
// Module   : estimador_func_mvmult_sat_round
// Brief    : Round-half-up, arithmetic shift by FRAC and saturate to W bits
// Revision : 1.0
// ============================================================================
module estimador_func_mvmult_sat_round
   import estimador_func_mvmult_pkg::*;
#(
   parameter int ACC_W = 67,
   parameter int W     = 32,
   parameter int FRAC  = 16,
   parameter int TAG_W = 2
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    in_vld,
   input  logic signed [ACC_W-1:0] acc_in,
   input  logic [TAG_W-1:0]        tag_in,
   output logic [W-1:0]            y_out,
   output logic [TAG_W-1:0]        y_tag,
   output logic                    y_vld
);

   localparam logic signed [ACC_W:0] c_rnd     = (ACC_W+1)'(1) <<< (FRAC - 1);
   localparam logic signed [ACC_W:0] c_sat_max = (ACC_W+1)'(sat_max(W));
   localparam logic signed [ACC_W:0] c_sat_min = (ACC_W+1)'(sat_min(W));

   logic signed [ACC_W:0] w_t;
   logic signed [ACC_W:0] w_s;
   logic [W-1:0]          w_sat;

   // One extra bit so the rounding offset can never wrap the accumulator
   always_comb begin
      w_t   = (ACC_W+1)'(acc_in) + c_rnd;
      w_s   = w_t >>> FRAC;
      w_sat = w_s[W-1:0];
      if (w_s > c_sat_max)
         w_sat = c_sat_max[W-1:0];
      else if (w_s < c_sat_min)
         w_sat = c_sat_min[W-1:0];
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         y_out <= '0;
         y_tag <= '0;
         y_vld <= 1'b0;
      end else begin
         y_vld <= in_vld;
         if (in_vld) begin
            y_out <= w_sat;
            y_tag <= tag_in;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/estimador_func_mvmult_param.sv
`default_nettype none
// ============================================================================
// Module   : estimador_func_mvmult_param
// Brief    : y = A*x, one MAC per cycle, single round/saturate per row
// Revision : 1.0
// ============================================================================
module estimador_func_mvmult_param
   import estimador_func_mvmult_pkg::*;
#(
   parameter int W      = 32,
   parameter int FRAC   = 16,
   parameter int ROWS   = 3,
   parameter int COLS   = 3,
   parameter int ADDR_W = clog2_min1(ROWS * COLS),
   parameter int ACC_W  = 2 * W + clog2(COLS) + 1
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst_n,
   input  logic                            ap_start,
   output logic                            ap_ready,
   output logic                            ap_done,
   output logic                            ap_idle,
   input  logic [COLS*W-1:0]               x_in,
   input  logic                            coef_we,
   input  logic [ADDR_W-1:0]               coef_addr,
   input  logic [W-1:0]                    coef_din,
   output logic [W-1:0]                    y_out,
   output logic [clog2_min1(ROWS)-1:0]     y_idx,
   output logic                            y_vld
);

   localparam int IDX_W = clog2_min1(ROWS);
   localparam int COL_W = clog2_min1(COLS);
   localparam int N     = ROWS * COLS;
   localparam logic [ADDR_W:0] c_n_coef = (ADDR_W+1)'(N);

   state_t r_state, w_state_nxt;
   logic   w_accept, w_issue, w_last_issue;

   logic [IDX_W-1:0]  r_row;
   logic [COL_W-1:0]  r_col;
   logic [ADDR_W-1:0] r_idx, w_raddr;

   logic signed [W-1:0] r_x [COLS];
   logic [W-1:0]        r_coef [N];
   logic signed [W-1:0] r_rdata;

   logic signed [2*W-1:0]   w_prod, r_prod;
   logic                    r_p_vld, r_p_first, r_p_last;
   logic [IDX_W-1:0]        r_p_row;
   logic signed [ACC_W-1:0] w_prod_ext, w_acc_nxt, r_acc;
   logic                    r_a_vld, r_a_done;
   logic [IDX_W-1:0]        r_a_row;
   logic                    r_ready, r_done;

   assign w_last_issue = (r_row == IDX_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1));

   // The RAM address leads the issue counter by one cycle so the coefficient
   // for (r,c) is already registered when (r,c) is issued.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_raddr     = r_idx + 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_raddr = '0;
            if (ap_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_issue = 1'b1;
            if (w_last_issue) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_done) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_idx   <= '0;
         r_ready <= 1'b0;
         for (int i = 0; i < COLS; i++) r_x[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= w_accept;
         if (w_accept) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
            for (int i = 0; i < COLS; i++) r_x[i] <= x_in[i*W +: W];
         end else if (w_issue) begin
            r_idx <= r_idx + 1'b1;
            if (r_col == COL_W'(COLS - 1)) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   // Coefficient storage is deliberately left out of reset
   always_ff @(posedge ap_clk) begin
      if (coef_we && (r_state == ST_IDLE) && ({1'b0, coef_addr} < c_n_coef))
         r_coef[coef_addr] <= coef_din;
      if ({1'b0, w_raddr} < c_n_coef)
         r_rdata <= r_coef[w_raddr];
   end

   assign w_prod     = (2*W)'(r_rdata) * (2*W)'(r_x[r_col]);
   assign w_prod_ext = ACC_W'(r_prod);
   assign w_acc_nxt  = r_p_first ? w_prod_ext : (r_acc + w_prod_ext);

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_p_vld   <= 1'b0;
         r_p_first <= 1'b0;
         r_p_last  <= 1'b0;
         r_p_row   <= '0;
         r_prod    <= '0;
         r_acc     <= '0;
         r_a_vld   <= 1'b0;
         r_a_done  <= 1'b0;
         r_a_row   <= '0;
         r_done    <= 1'b0;
      end else begin
         r_p_vld <= w_issue;
         if (w_issue) begin
            r_prod    <= w_prod;
            r_p_first <= (r_col == '0);
            r_p_last  <= (r_col == COL_W'(COLS - 1));
            r_p_row   <= r_row;
         end
         if (r_p_vld) r_acc <= w_acc_nxt;
         r_a_vld  <= r_p_vld && r_p_last;
         r_a_done <= r_p_vld && r_p_last && (r_p_row == IDX_W'(ROWS - 1));
         r_a_row  <= r_p_row;
         r_done   <= r_a_done;
      end
   end

   estimador_func_mvmult_sat_round #(
      .ACC_W (ACC_W),
      .W     (W),
      .FRAC  (FRAC),
      .TAG_W (IDX_W)
   ) u_sat_round (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .in_vld   (r_a_vld),
      .acc_in   (r_acc),
      .tag_in   (r_a_row),
      .y_out    (y_out),
      .y_tag    (y_idx),
      .y_vld    (y_vld)
   );

   assign ap_idle  = (r_state == ST_IDLE);
   assign ap_ready = r_ready;
   assign ap_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_estimador_func_mvmult_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_estimador_func_mvmult_param
// Brief    : Directed scoreboard bench for the 3x3 Q16.16 matrix-vector multiplier
// Revision : 1.0
// ============================================================================
module tb_estimador_func_mvmult_param;

   localparam int W    = 32;
   localparam int ROWS = 3;
   localparam int COLS = 3;
   localparam int N    = ROWS * COLS;

   logic             ap_clk = 1'b0;
   logic             ap_rst_n = 1'b0;
   logic             ap_start = 1'b0;
   logic             coef_we = 1'b0;
   logic [3:0]       coef_addr = '0;
   logic [W-1:0]     coef_din = '0;
   logic [COLS*W-1:0] x_in = '0;
   logic             ap_ready, ap_done, ap_idle, y_vld;
   logic [W-1:0]     y_out;
   logic [1:0]       y_idx;

   typedef struct {
      logic [31:0] y;
      int          idx;
      logic        done;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   logic [31:0] m_coef [N];
   logic [31:0] m_x [COLS];

   estimador_func_mvmult_param dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .ap_start  (ap_start),
      .ap_ready  (ap_ready),
      .ap_done   (ap_done),
      .ap_idle   (ap_idle),
      .x_in      (x_in),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_din  (coef_din),
      .y_out     (y_out),
      .y_idx     (y_idx),
      .y_vld     (y_vld)
   );

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (failure %0d)", tag, obs, exp, n_fail);
      end
   endtask

   // Sample at the falling edge, then advance to just after the next rising edge
   task automatic step();
      exp_t e;
      @(negedge ap_clk);
      if (y_vld === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_y_vld", 64'(y_vld), 64'd0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("y_out[row%0d]", e.idx), 64'(y_out), 64'(e.y));
            chk($sformatf("y_idx[row%0d]", e.idx), 64'(y_idx), 64'(e.idx));
            chk($sformatf("ap_done[row%0d]", e.idx), 64'(ap_done), 64'(e.done));
            chk($sformatf("y_vld_cycle[row%0d]", e.idx), 64'(cyc), 64'(e.cyc));
         end
      end
      @(posedge ap_clk);
      #1;
   endtask

   task automatic load_coefs();
      for (int i = 0; i < N; i++) begin
         coef_we   = 1'b1;
         coef_addr = 4'(i);
         coef_din  = m_coef[i];
         step();
      end
      coef_we = 1'b0;
   endtask

   task automatic push_run(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input int s);
      sb.push_back('{e0, 0, 1'b0, s + 6});
      sb.push_back('{e1, 1, 1'b0, s + 9});
      sb.push_back('{e2, 2, 1'b1, s + 12});
   endtask

   task automatic launch(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
      x_in = {m_x[2], m_x[1], m_x[0]};
      push_run(e0, e1, e2, cyc);
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      chk("ap_ready_pulse", 64'(ap_ready), 64'd1);
      chk("ap_idle_busy", 64'(ap_idle), 64'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 80) begin
         step();
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout_pending", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic run(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
      launch(e0, e1, e2);
      drain();
      chk("ap_idle_after_run", 64'(ap_idle), 64'd1);
      chk("ap_ready_after_run", 64'(ap_ready), 64'd0);
   endtask

   function automatic logic [31:0] model(input int r);
      logic signed [127:0] acc;
      logic signed [127:0] s;
      acc = '0;
      for (int c = 0; c < COLS; c++)
         acc = acc + 128'($signed(m_coef[r*COLS + c])) * 128'($signed(m_x[c]));
      acc = acc + 128'sd32768;
      s   = acc >>> 16;
      if (s > 128'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -128'sd2147483648) return 32'h8000_0000;
      return s[31:0];
   endfunction

   task automatic set_identity();
      for (int i = 0; i < N; i++) m_coef[i] = (i % (COLS + 1) == 0) ? 32'h0001_0000 : 32'h0;
      m_x[0] = 32'h0001_8000;
      m_x[1] = 32'hFFFE_0000;
      m_x[2] = 32'h0000_7FFF;
   endtask

   task automatic set_legacy();
      for (int i = 0; i < N; i++) m_coef[i] = 32'h0;
      m_coef[0] = 32'd931783;
      m_coef[3] = 32'd69566;
      m_coef[6] = 32'd598944;
      m_x[0] = 32'h0002_0000;
      m_x[1] = 32'h0001_2345;
      m_x[2] = 32'hFFF0_0000;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s;
      // Reset state
      ap_rst_n = 1'b0;
      repeat (3) step();
      chk("rst_y_out", 64'(y_out), 64'd0);
      chk("rst_y_idx", 64'(y_idx), 64'd0);
      chk("rst_y_vld", 64'(y_vld), 64'd0);
      chk("rst_ap_done", 64'(ap_done), 64'd0);
      chk("rst_ap_ready", 64'(ap_ready), 64'd0);
      chk("rst_ap_idle", 64'(ap_idle), 64'd1);
      ap_rst_n = 1'b1;
      step();

      // Identity
      set_identity();
      load_coefs();
      run(32'h0001_8000, 32'hFFFE_0000, 32'h0000_7FFF);

      // Legacy row values
      set_legacy();
      load_coefs();
      run(32'd1863566, 32'd139132, 32'd1197888);

      // Saturation, both rails
      for (int i = 0; i < N; i++) m_coef[i] = 32'h7FFF_FFFF;
      for (int c = 0; c < COLS; c++) m_x[c] = 32'h7FFF_FFFF;
      load_coefs();
      run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      for (int c = 0; c < COLS; c++) m_x[c] = 32'h8000_0000;
      run(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);

      // Reset in cycle 5 of an identity run
      set_identity();
      load_coefs();
      x_in = {m_x[2], m_x[1], m_x[0]};
      s = cyc;
      push_run(32'h0001_8000, 32'hFFFE_0000, 32'h0000_7FFF, s);
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      while (cyc < s + 5) step();
      ap_rst_n = 1'b0;
      sb.delete();
      step();
      chk("midrst_y_out", 64'(y_out), 64'd0);
      chk("midrst_y_idx", 64'(y_idx), 64'd0);
      chk("midrst_y_vld", 64'(y_vld), 64'd0);
      chk("midrst_ap_done", 64'(ap_done), 64'd0);
      chk("midrst_ap_ready", 64'(ap_ready), 64'd0);
      chk("midrst_ap_idle", 64'(ap_idle), 64'd1);
      ap_rst_n = 1'b1;
      step();
      run(32'h0001_8000, 32'hFFFE_0000, 32'h0000_7FFF);

      // Rounding: a single half-weight coefficient
      for (int i = 0; i < N; i++) m_coef[i] = 32'h0;
      m_coef[0] = 32'h0000_8000;
      load_coefs();
      m_x[1] = 32'h0000_0055;
      m_x[2] = 32'h0000_0066;
      m_x[0] = 32'h0000_0001;
      run(32'h0000_0001, 32'h0, 32'h0);
      m_x[0] = 32'hFFFF_FFFF;
      run(32'h0, 32'h0, 32'h0);
      m_x[0] = 32'hFFFF_FFFE;
      run(32'hFFFF_FFFF, 32'h0, 32'h0);

      // Busy protection: coefficient writes and start requests mid-run
      set_legacy();
      load_coefs();
      launch(32'd1863566, 32'd139132, 32'd1197888);
      for (int k = 0; k < 4; k++) begin
         coef_we   = 1'b1;
         coef_addr = (k % 2 == 0) ? 4'd0 : 4'd3;
         coef_din  = 32'hDEAD_BEEF;
         ap_start  = 1'b1;
         step();
      end
      coef_we  = 1'b0;
      ap_start = 1'b0;
      drain();
      repeat (8) step();
      chk("busy_no_extra_run_idle", 64'(ap_idle), 64'd1);
      run(32'd1863566, 32'd139132, 32'd1197888);

      // ap_start held: back-to-back accept at cycle 13
      set_identity();
      load_coefs();
      x_in = {m_x[2], m_x[1], m_x[0]};
      s = cyc;
      push_run(32'h0001_8000, 32'hFFFE_0000, 32'h0000_7FFF, s);
      push_run(32'h0001_8000, 32'hFFFE_0000, 32'h0000_7FFF, s + 13);
      ap_start = 1'b1;
      step();
      chk("held_ready_first", 64'(ap_ready), 64'd1);
      while (cyc < s + 13) step();
      chk("held_idle_cycle13", 64'(ap_idle), 64'd1);
      step();
      chk("held_ready_second", 64'(ap_ready), 64'd1);
      ap_start = 1'b0;
      drain();
      chk("held_idle_after", 64'(ap_idle), 64'd1);

      // Random matrices against the bench's reference model
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) m_coef[i] = $urandom();
         for (int c = 0; c < COLS; c++) m_x[c] = (k == 0) ? ($urandom() >> 12) : $urandom();
         load_coefs();
         run(model(0), model(1), model(2));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
